control_multiciclo: RTL

Multi-cycle RISC-V (RV32I subset) control FSM that sequences the shared datapath: instruction fetch, immediate generation, ALU, memory and register-file writeback.
- Drives the immediate generator's 2-bit ImmSel (I=00, J=01, B=10, S=11) and selects the separate U-immediate path.
- Issues memory requests using a req/ready handshake.
- Sits between the instruction register/memory port and the datapath muxes.

---
 rtl/riscv_ctrl_pkg.sv | 53 +++++
 rtl/branch_eval.sv | 26 ++
 rtl/control_multiciclo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// immediate formats, ALU/PC/writeback select codes and error codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_J = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_S = 2'b11;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  localparam logic [1:0] PC_PLUS4     = 2'b00;
  localparam logic [1:0] PC_ALU       = 2'b01;
  localparam logic [1:0] PC_ALU_ALIGN = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_known_opcode(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluation from funct3 and the datapath comparator flags.
// funct3 010/011 are not branch encodings and are flagged illegal.
module branch_eval (
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:  taken = br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken = br_ltu;
      3'b111:  taken = ~br_ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback over a shared datapath, with memory wait timeout and sticky error code.
module control_multiciclo
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  input  logic       mem_ready,
  output logic [1:0] ImmSel,
  output logic       ImmUSel,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSel,
  output logic       RegWrite,
  output logic       MemReq,
  output logic       MemWE,
  output logic       ASel,
  output logic       BSel,
  output logic [3:0] ALUOp,
  output logic [1:0] WBSel,
  output logic [1:0] err_code,
  output logic [2:0] state_dbg
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             br_taken, br_illegal;
  logic             wait_expired;

  branch_eval u_branch_eval (
    .funct3 (funct3),
    .br_eq  (br_eq),
    .br_lt  (br_lt),
    .br_ltu (br_ltu),
    .taken  (br_taken),
    .illegal(br_illegal)
  );

  assign wait_expired = (cnt_q == CNT_W'(MEM_WAIT_MAX));
  assign err_code     = err_q;
  assign state_dbg    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Immediate format is held for the whole life of the decoded instruction.
  always_comb begin
    ImmSel  = IMM_I;
    ImmUSel = 1'b0;
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      case (opcode)
        OPC_JAL:            ImmSel = IMM_J;
        OPC_BRANCH:         ImmSel = IMM_B;
        OPC_STORE:          ImmSel = IMM_S;
        OPC_LUI, OPC_AUIPC: ImmUSel = 1'b1;
        default:            ImmSel = IMM_I;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSel    = PC_PLUS4;
    RegWrite = 1'b0;
    MemReq   = 1'b0;
    MemWE    = 1'b0;
    ASel     = 1'b0;
    BSel     = 1'b0;
    ALUOp    = ALU_ADD;
    WBSel    = WB_ALU;

    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end

      S_FETCH: begin
        MemReq = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          cnt_d   = '0;
          err_d   = ERR_TIMEOUT;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        if (!is_known_opcode(opcode) || (opcode == OPC_BRANCH && br_illegal)) begin
          err_d   = ERR_ILLEGAL;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_WB;
        case (opcode)
          OPC_OP:    ALUOp = {funct7_5, funct3};
          OPC_OPIMM: begin
            BSel  = 1'b1;
            // Only shifts use funct7_5 (SRLI/SRAI); SUBI does not exist.
            ALUOp = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
          end
          OPC_LOAD, OPC_STORE: begin
            BSel    = 1'b1;
            state_d = S_MEM;
          end
          OPC_LUI: begin
            BSel  = 1'b1;
            ALUOp = ALU_PASS_B;
          end
          OPC_AUIPC, OPC_JAL: begin
            ASel = 1'b1;
            BSel = 1'b1;
          end
          OPC_JALR:  BSel = 1'b1;
          OPC_BRANCH: begin
            ASel    = 1'b1;
            BSel    = 1'b1;
            PCWrite = 1'b1;
            PCSel   = br_taken ? PC_ALU : PC_PLUS4;
            state_d = S_FETCH;
          end
          default:   state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        MemReq = 1'b1;
        MemWE  = (opcode == OPC_STORE);
        if (mem_ready) begin
          cnt_d = '0;
          if (opcode == OPC_STORE) begin
            PCWrite = 1'b1;
            PCSel   = PC_PLUS4;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          cnt_d   = '0;
          err_d   = ERR_TIMEOUT;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
        case (opcode)
          OPC_LOAD: WBSel = WB_MEM;
          OPC_JAL: begin
            WBSel = WB_PC4;
            PCSel = PC_ALU;
          end
          OPC_JALR: begin
            WBSel = WB_PC4;
            PCSel = PC_ALU_ALIGN;
          end
          default: WBSel = WB_ALU;
        endcase
      end

      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_RST;
    endcase
  end

endmodule
